data_mem_responder: RTL and testbench

//  Memory-side responder for the MEM-stage data port (address/data/wren/rden/q) of the mips32 pipeline.

---
 rtl/data_mem_responder_pkg.sv | 23 ++
 rtl/data_mem_responder_array.sv | 36 +++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the MEM-stage data memory responder.
//   DATA_MEM_ADDR_SIZE : default word-address width of the data memory
//   DMEM_IO_OFFSET     : word address of the memory-mapped output register
//   DMEM_CNT_OFFSET    : word address of the read-only cycle counter
//   dmem_state_e       : responder FSM states
//   rd_sel_e           : source of the registered read data
package data_mem_responder_pkg;

  localparam int unsigned DATA_MEM_ADDR_SIZE = 10;
  localparam int unsigned DMEM_IO_OFFSET     = (1 << DATA_MEM_ADDR_SIZE) - 1;
  localparam int unsigned DMEM_CNT_OFFSET    = (1 << DATA_MEM_ADDR_SIZE) - 2;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } dmem_state_e;

  typedef enum logic {
    RSEL_RAM,
    RSEL_REG
  } rd_sel_e;

endpackage

// File: rtl/data_mem_responder_array.sv
// dmem_array: single-port RAM, synchronous write and synchronous read.
// When we and re are both high, the read returns the data being written.
// The read register holds its value while re is low.
//   clk   : clock
//   we    : write enable
//   re    : read enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module dmem_array #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= we ? wdata : mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the pipeline's MEM-stage data
// port. Holds a word RAM, a memory-mapped output register and a read-only
// cycle counter. After reset every RAM word is cleared while busy is high.
// Reads have one cycle of latency (q/q_valid registered at the request edge).
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   address : word address
//   data    : write data
//   wren    : write request
//   rden    : read request
//   q       : read data, held between reads
//   q_valid : one-cycle pulse per accepted read
//   busy    : high while the clear sequence runs
//   io_out  : memory-mapped output register
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DATA_MEM_ADDR_SIZE,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR    = '1,
  parameter logic [ADDR_WIDTH-1:0] CNT_ADDR   = {{(ADDR_WIDTH-1){1'b1}}, 1'b0}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] io_out
);

  dmem_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] io_q, io_d;
  // Register-sourced read data (io_out / counter) and the mux select for q.
  // Reset selects this register (cleared to 0) so q is defined before the
  // RAM read register has ever been loaded.
  logic [DATA_WIDTH-1:0] aux_q, aux_d;
  rd_sel_e               sel_q, sel_d;
  logic                  q_valid_q, q_valid_d;

  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  logic is_io, is_cnt;

  assign is_io  = (address == IO_ADDR);
  assign is_cnt = (address == CNT_ADDR);

  dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cnt_d      = cnt_q;
    io_d       = io_q;
    aux_d      = aux_q;
    sel_d      = sel_q;
    q_valid_d  = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = address;
    ram_wdata  = data;

    case (state_q)
      ST_CLEAR: begin
        ram_we     = 1'b1;
        ram_addr   = clr_addr_q;
        ram_wdata  = '0;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        cnt_d = cnt_q + DATA_WIDTH'(1);
        if (wren) begin
          if (is_io) begin
            io_d = data;
          end else if (!is_cnt) begin
            ram_we = 1'b1;
          end
        end
        if (rden) begin
          q_valid_d = 1'b1;
          if (is_io) begin
            sel_d = RSEL_REG;
            aux_d = wren ? data : io_q;   // write-first on the output register
          end else if (is_cnt) begin
            sel_d = RSEL_REG;
            aux_d = cnt_q;
          end else begin
            sel_d  = RSEL_RAM;
            ram_re = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      cnt_q      <= '0;
      io_q       <= '0;
      aux_q      <= '0;
      sel_q      <= RSEL_REG;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cnt_q      <= cnt_d;
      io_q       <= io_d;
      aux_q      <= aux_d;
      sel_q      <= sel_d;
      q_valid_q  <= q_valid_d;
    end
  end

  assign q       = (sel_q == RSEL_RAM) ? ram_rdata : aux_q;
  assign q_valid = q_valid_q;
  assign busy    = (state_q == ST_CLEAR);
  assign io_out  = io_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam logic [3:0]  A_IO  = 4'd15;
  localparam logic [3:0]  A_CNT = 4'd14;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          wren;
  logic          rden;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          busy;
  logic [DW-1:0] io_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .data    (data),
    .wren    (wren),
    .rden    (rden),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy),
    .io_out  (io_out)
  );

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_q;
    logic          exp_qv;
    logic [DW-1:0] exp_io;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wren    = wr;
    rden    = rd;
    address = a;
    data    = d;
  endtask

  // Counts samples with busy high, starting right after the reset edge.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (q_valid !== 1'b0) chk("clear_qv", {31'd0, q_valid}, 32'd0);
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] c1;

    vecs[0]  = '{1'b1, 1'b0, 4'd3,  32'hDEADBEEF, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 4'd3,  32'h0,        32'hDEADBEEF, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'd3,  32'h0,        32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 4'd5,  32'h12345678, 32'h12345678, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 4'd5,  32'h0,        32'h12345678, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, A_IO,  32'h000000A5, 32'h12345678, 1'b0, 32'hA5};
    vecs[6]  = '{1'b0, 1'b1, A_IO,  32'h0,        32'h000000A5, 1'b1, 32'hA5};
    vecs[7]  = '{1'b1, 1'b0, A_CNT, 32'h12345678, 32'h000000A5, 1'b0, 32'hA5};
    vecs[8]  = '{1'b1, 1'b1, A_IO,  32'h00000077, 32'h00000077, 1'b1, 32'h77};
    vecs[9]  = '{1'b1, 1'b0, 4'd2,  32'h00002222, 32'h00000077, 1'b0, 32'h77};
    vecs[10] = '{1'b0, 1'b1, 4'd2,  32'h0,        32'h00002222, 1'b1, 32'h77};
    vecs[11] = '{1'b0, 1'b1, 4'd3,  32'h0,        32'hDEADBEEF, 1'b1, 32'h77};

    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_q", q, 32'h0);
    chk("rst_qv", {31'd0, q_valid}, 32'd0);
    chk("rst_io", io_out, 32'h0);

    rst = 1'b0;
    count_busy(n);
    chk("clear_len", n, 16);

    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b1, AW'(i), '0);
      step();
      chk($sformatf("clr_q[%0d]", i), q, 32'h0);
      chk($sformatf("clr_qv[%0d]", i), {31'd0, q_valid}, 32'd1);
    end
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk("idle_qv", {31'd0, q_valid}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      step();
      chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      chk($sformatf("vec%0d_qv", i), {31'd0, q_valid}, {31'd0, vecs[i].exp_qv});
      chk($sformatf("vec%0d_io", i), io_out, vecs[i].exp_io);
    end

    // Cycle counter: two reads 10 edges apart differ by exactly 10.
    drive(1'b0, 1'b1, A_CNT, '0);
    step();
    c1 = q;
    chk("cnt1_qv", {31'd0, q_valid}, 32'd1);
    chk("cnt1_small", {31'd0, (c1 < 32'd200)}, 32'd1);
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 9; i++) step();
    chk("cnt_hold", q, c1);
    drive(1'b0, 1'b1, A_CNT, '0);
    step();
    chk("cnt_delta", q - c1, 32'd10);
    drive(1'b0, 1'b0, '0, '0);

    // Reset in the middle of a clear, with requests active.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'd2, 32'h00000BAD);
    step();
    rst = 1'b0;
    chk("rerst_io", io_out, 32'h0);
    chk("rerst_q", q, 32'h0);
    count_busy(n);
    drive(1'b0, 1'b0, '0, '0);
    chk("reclear_len", n, 16);
    drive(1'b0, 1'b1, 4'd2, '0);
    step();
    chk("reclear_q2", q, 32'h0);
    chk("reclear_qv", {31'd0, q_valid}, 32'd1);
    drive(1'b0, 1'b0, '0, '0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
